// File: rtl/mcu_spi.sv
// SPI mode-0 slave that routes MCU frames to one of four byte targets.
// Frame layout: target-ID byte, then payload bytes strobed to that target; replies shift back on MISO.
module mcu_spi (
  input  logic       clk,
  input  logic       reset,
  input  logic       spi_io_ss,
  input  logic       spi_io_clk,
  input  logic       spi_io_din,
  output logic       spi_io_dout,
  output logic       mcu_sys_strobe,
  output logic       mcu_hid_strobe,
  output logic       mcu_osd_strobe,
  output logic       mcu_sdc_strobe,
  output logic       mcu_start,
  output logic [7:0] mcu_dout,
  input  logic [7:0] mcu_sys_din,
  input  logic [7:0] mcu_hid_din,
  input  logic [7:0] mcu_osd_din,
  input  logic [7:0] mcu_sdc_din
);

  typedef enum logic [1:0] {S_IDLE, S_TARGET, S_FIRST, S_DATA} state_t;

  logic [1:0] r_ss_s, r_sck_s, r_din_s;
  logic       r_sck_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ss_s  <= 2'b11;
      r_sck_s <= 2'b00;
      r_din_s <= 2'b00;
      r_sck_d <= 1'b0;
    end else begin
      r_ss_s  <= {r_ss_s[0], spi_io_ss};
      r_sck_s <= {r_sck_s[0], spi_io_clk};
      r_din_s <= {r_din_s[0], spi_io_din};
      r_sck_d <= r_sck_s[1];
    end
  end

  logic w_ss, w_din, w_rise, w_fall;
  assign w_ss   = r_ss_s[1];
  assign w_din  = r_din_s[1];
  assign w_rise = r_sck_s[1] & ~r_sck_d;
  assign w_fall = ~r_sck_s[1] & r_sck_d;

  logic [2:0] r_bitcnt;
  logic [6:0] r_rx;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_bitcnt <= 3'd0;
      r_rx     <= 7'd0;
    end else begin
      if (w_ss)        r_bitcnt <= 3'd0;
      else if (w_rise) r_bitcnt <= r_bitcnt + 3'd1;
      if (w_rise)      r_rx <= {r_rx[5:0], w_din};
    end
  end

  // Not gated by ss: a byte finishing on the same cycle ss rises is still delivered.
  logic       w_byte_done;
  logic [7:0] w_byte;
  assign w_byte_done = w_rise && (r_bitcnt == 3'd7);
  assign w_byte      = {r_rx, w_din};

  // The synchronizer resets to ss=1, so ignore w_ss until real samples have flushed through;
  // only a genuine ss-high after reset re-arms framing.
  logic [1:0] r_warm;
  logic       r_armed;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_warm  <= 2'b00;
      r_armed <= 1'b0;
    end else begin
      r_warm <= {r_warm[0], 1'b1};
      if (w_ss && r_warm[1]) r_armed <= 1'b1;
    end
  end

  state_t     r_state;
  logic [7:0] r_tid;
  logic [3:0] r_stb;
  logic       r_start;
  logic [7:0] r_dout;
  logic       w_tid_ok;
  logic [3:0] w_sel;

  assign w_tid_ok = (r_tid[7:2] == 6'd0);
  assign w_sel    = 4'b0001 << r_tid[1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_tid   <= 8'd0;
      r_stb   <= 4'd0;
      r_start <= 1'b0;
      r_dout  <= 8'd0;
    end else begin
      r_stb <= 4'd0;
      if (w_byte_done && r_state != S_IDLE) begin
        case (r_state)
          S_TARGET: begin
            r_tid   <= w_byte;
            r_state <= S_FIRST;
          end
          S_FIRST, S_DATA: begin
            if (w_tid_ok) begin
              r_stb   <= w_sel;
              r_dout  <= w_byte;
              r_start <= (r_state == S_FIRST);
            end
            r_state <= S_DATA;
          end
          default: r_state <= S_IDLE;
        endcase
      end else if (w_ss) begin
        r_state <= S_IDLE;
      end else if (r_state == S_IDLE && r_armed) begin
        r_state <= S_TARGET;
      end
    end
  end

  assign mcu_sys_strobe = r_stb[0];
  assign mcu_hid_strobe = r_stb[1];
  assign mcu_osd_strobe = r_stb[2];
  assign mcu_sdc_strobe = r_stb[3];
  assign mcu_start      = r_start;
  assign mcu_dout       = r_dout;

  logic [7:0] w_reply;
  always_comb begin
    w_reply = 8'd0;
    case (r_tid[1:0])
      2'd0: w_reply = mcu_sys_din;
      2'd1: w_reply = mcu_hid_din;
      2'd2: w_reply = mcu_osd_din;
      2'd3: w_reply = mcu_sdc_din;
      default: w_reply = 8'd0;
    endcase
  end

  logic       r_ld;
  logic [7:0] r_tx;

  // The trailing fall after bit 0 (counter back at 0) is skipped so the freshly
  // loaded bit 7 survives until the first rise of the next byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ld <= 1'b0;
      r_tx <= 8'd0;
    end else begin
      r_ld <= |r_stb;
      if (w_ss)                          r_tx <= 8'd0;
      else if (r_ld)                     r_tx <= w_reply;
      else if (w_fall && r_bitcnt != 0)  r_tx <= {r_tx[6:0], 1'b0};
    end
  end

  assign spi_io_dout = r_tx[7] & ~w_ss;

endmodule

// File: doc/mcu_spi.md
MCU_SPI -- requirements
Module: mcu_spi

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single system clock; every register is clocked on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port spi_io_ss, input, 1 bit: MCU chip select, active low, asynchronous to clk.
REQ-004 SHALL have port spi_io_clk, input, 1 bit: SPI clock, mode 0, asynchronous to clk, frequency at most clk/8.
REQ-005 SHALL have port spi_io_din, input, 1 bit: MOSI, MSB first.
REQ-006 SHALL have port spi_io_dout, output, 1 bit: MISO, MSB first.
REQ-007 SHALL have ports mcu_sys_strobe, mcu_hid_strobe, mcu_osd_strobe and mcu_sdc_strobe, each an output of 1 bit: one-cycle byte-valid pulse to the named target.
REQ-008 SHALL have port mcu_start, output, 1 bit: qualifies the strobe that carries the first payload byte of a frame.
REQ-009 SHALL have port mcu_dout, output, 8 bits: received payload byte, shared by all targets.
REQ-010 SHALL have ports mcu_sys_din, mcu_hid_din, mcu_osd_din and mcu_sdc_din, each an input of 8 bits: reply byte from the named target.

Function
REQ-011 SHALL pass spi_io_ss, spi_io_clk and spi_io_din through two-flop synchronizers, then detect SCLK edges with a third flop.
REQ-012 SHALL sample MOSI on each synchronized SCLK rising edge while ss is low, shifting MSB first.
REQ-013 SHALL keep a 3-bit bit counter that is cleared while ss is high and wraps from 7 to 0.
REQ-014 SHALL treat the rising edge on which the counter wraps as byte-complete.
REQ-015 SHALL run a frame FSM with states IDLE, TARGET, FIRST and DATA.
REQ-016 SHALL force the FSM to IDLE while ss is high, and SHALL move IDLE->TARGET on the cycle ss is seen low.
REQ-017 SHALL, on byte-complete in TARGET, latch the byte as target ID (0x00=sys, 0x01=hid, 0x02=osd, 0x03=sdc), emit no strobe, and go to FIRST.
REQ-018 SHALL, on byte-complete in FIRST, drive mcu_dout=byte, mcu_start=1 and the selected target's strobe for exactly one cycle, then go to DATA.
REQ-019 SHALL, on byte-complete in DATA, drive the same pulse with mcu_start=0 and remain in DATA.
REQ-020 SHALL emit no strobe for a target ID above 0x03 and SHALL return 0x00 on MISO for the rest of that frame.
REQ-021 SHALL keep mcu_dout and mcu_start valid from the strobe cycle until the next strobe.
REQ-022 SHALL load the TX shift register from the selected target's din exactly 2 clk cycles after each strobe, so the target has one cycle to register its reply.
REQ-023 SHALL drive TX bit 7 on spi_io_dout at load and shift on each synchronized SCLK falling edge; the reply therefore appears during the following byte.
REQ-024 SHALL drive 0x00 on MISO during the target byte and the first payload byte.
REQ-025 SHALL discard a partial byte when ss rises mid-byte: no strobe, counter cleared, FSM to IDLE.
REQ-026 SHALL always complete a strobe already issued, even if ss rises in the same cycle.
REQ-027 SHALL give byte-complete priority over ss deassertion when both occur in the same cycle; the byte is delivered.
REQ-028 SHALL hold spi_io_dout at 0 while ss is high.

Reset
REQ-029 SHALL, while reset=1, set the FSM to IDLE, the bit counter to 0, all strobes to 0, mcu_start to 0, mcu_dout to 0x00, the TX register to 0x00 and spi_io_dout to 0.
REQ-030 SHALL let reset abort a frame in progress; bytes following reset are ignored until ss goes high and then low again.
REQ-031 SHALL reset the synchronizer flops to the idle levels ss=1 and sclk=0.

Verification
REQ-032 SHALL be verified by: frame 00,00,xx,xx,xx with mcu_sys_din returning 5C,42,02 -> mcu_sys_strobe pulses 4 times, mcu_start=1 on the first pulse only, mcu_dout=00 on the first pulse, MISO reads 00,00,5C,42,02.
REQ-033 SHALL be verified by: frame 02,A5,3C -> mcu_osd_strobe pulses twice with A5 then 3C, and no other strobe fires.
REQ-034 SHALL be verified by: frame 07,11 -> no strobe at all and MISO=00,00.
REQ-035 SHALL be verified by: ss raised after 4 bits of the second byte -> no strobe; a following frame 00,01 yields a single strobe with mcu_start=1 and mcu_dout=01.
REQ-036 SHALL be verified by: reset pulsed mid-frame -> all outputs 0 on the next cycle, with no strobe until a new ss falling edge.
REQ-037 SHALL be verified by: SCLK at exactly clk/8 with random payloads across 1000 frames -> every byte matches mcu_dout and one strobe fires per byte.
